// File: rtl/regfile_write_arbiter_pkg.sv
// Shared VLIW core types: functional-unit count and register-file geometry.
package vliw_pkg;
    localparam int NUM_FU     = 4;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int FU_ID_W    = $clog2(NUM_FU);

    typedef logic [FU_ID_W-1:0]    fu_id_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// FU request / back-pressure bundle and register-file write port.
// master = functional-unit side, slave = the write arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    localparam int ID_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]        req_valid;
    logic [NUM_FU*ADDR_W-1:0] req_addr;
    logic [NUM_FU*DATA_W-1:0] req_data;
    logic [NUM_FU-1:0]        fu_stall;
    logic                     bundle_stall;
    logic                     rf_we;
    logic [ADDR_W-1:0]        rf_waddr;
    logic [DATA_W-1:0]        rf_wdata;
    logic [ID_W-1:0]          grant_id;
    logic                     waw_error;

    modport master (
        output req_valid, req_addr, req_data,
        input  fu_stall, bundle_stall, rf_we, rf_waddr, rf_wdata, grant_id, waw_error
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output fu_stall, bundle_stall, rf_we, rf_waddr, rf_wdata, grant_id, waw_error
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i,
// ascending with wrap-around. Reusable for read-port sharing.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int pos;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            if (!any_o && req_i[pos]) begin
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
                any_o      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port sharing: one holding buffer per FU, drained one
// per cycle in round-robin order, with per-FU and bundle back-pressure and a
// sticky write-after-write conflict flag.
module regfile_write_arbiter
    import vliw_pkg::*;
#(
    parameter int NUM_FU = vliw_pkg::NUM_FU,
    parameter int DATA_W = vliw_pkg::REG_DATA_W,
    parameter int ADDR_W = vliw_pkg::REG_ADDR_W
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_FU);

    logic [NUM_FU-1:0]             pend_q, pend_d;
    logic [NUM_FU-1:0][ADDR_W-1:0] addr_q, addr_d, req_addr;
    logic [NUM_FU-1:0][DATA_W-1:0] data_q, data_d, req_data;
    logic [IW-1:0]                 rr_q, rr_d;
    logic                          waw_q, waw_d;

    logic [NUM_FU-1:0]             gnt_oh, stall, load;
    logic [IW-1:0]                 gnt_idx;
    logic                          gnt_any;

    assign req_addr = bus.req_addr;
    assign req_data = bus.req_data;

    rr_arbiter #(.N(NUM_FU)) u_arb (
        .req_i (pend_q),
        .ptr_i (rr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // A full buffer only blocks its FU when it is not draining this cycle.
    assign stall = bus.req_valid & pend_q & ~gnt_oh;

    // x0 writes are accepted but never occupy a buffer.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_load
        assign load[i] = bus.req_valid[i] & ~stall[i] & (req_addr[i] != '0);
    end

    // Buffer next state: drain the granted entry, then refill from accepts.
    always_comb begin
        pend_d = (pend_q & ~gnt_oh) | load;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (load[i]) begin
                addr_d[i] = req_addr[i];
                data_d[i] = req_data[i];
            end
        end
    end

    // Pointer moves just past the granted FU; holds when idle.
    always_comb begin
        rr_d = rr_q;
        if (gnt_any) rr_d = (int'(gnt_idx) == NUM_FU - 1) ? '0 : gnt_idx + IW'(1);
    end

    // Flag two live entries (after this edge) aimed at the same register.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = i + 1; j < NUM_FU; j++) begin
                if (pend_d[i] && pend_d[j] && addr_d[i] == addr_d[j] && addr_d[i] != '0)
                    hit = 1'b1;
            end
        end
        waw_d = waw_q | hit;
    end

    // State registers; reset discards every pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            rr_q   <= '0;
            waw_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            data_q <= data_d;
            rr_q   <= rr_d;
            waw_q  <= waw_d;
        end
    end

    assign bus.rf_we        = gnt_any;
    assign bus.rf_waddr     = gnt_any ? addr_q[gnt_idx] : '0;
    assign bus.rf_wdata     = gnt_any ? data_q[gnt_idx] : '0;
    assign bus.grant_id     = gnt_idx;
    assign bus.fu_stall     = stall;
    assign bus.bundle_stall = |stall;
    assign bus.waw_error    = waw_q;
endmodule
